// File: rtl/wallace_mul_arbiter.sv
// Round-robin front end that time-shares one external combinational Wallace multiplier
// between two requesters, holding operands for a fixed settle window before sampling.
module wallace_mul_arbiter #(
  parameter int WIDTH   = 5,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_p,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_p,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and the sender holds its payload until ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(MUL_LAT);

  state_t               state_q, state_d;
  logic                 ptr_q, ptr_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 id_q, id_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 grant1;

  // ptr_q holds the last-served requester; requester 1 wins a tie only if 0 went last.
  assign grant1 = req1_valid & (~req0_valid | ~ptr_q);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    p_d        = p_q;
    a_d        = a_q;
    b_d        = b_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          if (grant1) begin
            req1_ready = 1'b1;
            a_d        = req1_a;
            b_d        = req1_b;
          end else begin
            req0_ready = 1'b1;
            a_d        = req0_a;
            b_d        = req0_b;
          end
          id_d    = grant1;
          ptr_d   = grant1;
          cnt_d   = LAT_INIT;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // The tree has settled once the counter reaches 1; capture on this edge.
        if (cnt_q <= 4'd1) begin
          p_d     = mul_p;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b1;
      cnt_q   <= 4'd0;
      id_q    <= 1'b0;
      p_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      p_q     <= p_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign rsp_valid = (state_q == S_DONE);
  assign rsp_id    = id_q;
  assign rsp_p     = p_q;
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Bench for wallace_mul_arbiter: scoreboard against a round-robin/product model, plus a
// second instance with a longer settle window fed by a multiplier that is wrong until settled.
module tb_wallace_mul_arbiter;

  localparam int W    = 5;
  localparam int LAT  = 2;
  localparam int LAT4 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (MUL_LAT=2)
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           rsp_valid, rsp_ready, rsp_id, busy;
  logic [2*W-1:0] rsp_p, mul_p;
  logic [W-1:0]   mul_a, mul_b;
  logic [1:0]     dbg_state;

  // Settle-window instance (MUL_LAT=4)
  logic           f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
  logic [W-1:0]   f_req0_a, f_req0_b, f_req1_a, f_req1_b;
  logic           f_rsp_valid, f_rsp_ready, f_rsp_id, f_busy;
  logic [2*W-1:0] f_rsp_p, f_mul_p;
  logic [W-1:0]   f_mul_a, f_mul_b;
  logic [1:0]     f_dbg_state;

  wallace_mul_arbiter #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy), .dbg_state(dbg_state)
  );

  wallace_mul_arbiter #(.WIDTH(W), .MUL_LAT(LAT4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(f_req0_a), .req0_b(f_req0_b),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(f_req1_a), .req1_b(f_req1_b),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id), .rsp_p(f_rsp_p),
    .mul_a(f_mul_a), .mul_b(f_mul_b), .mul_p(f_mul_p), .busy(f_busy), .dbg_state(f_dbg_state)
  );

  // Multiplier models: output is the bitwise complement of the product until the operands
  // have been stable for LAT-1 cycles, so an early sample returns a wrong value.
  logic [2*W-1:0] prev_ab = '0, f_prev_ab = '0;
  int             age = 0, f_age = 0;
  logic           chg, f_chg;
  logic [2*W-1:0] true_p, f_true_p;
  assign chg      = ({mul_a, mul_b} != prev_ab);
  assign f_chg    = ({f_mul_a, f_mul_b} != f_prev_ab);
  assign true_p   = {5'b0, mul_a} * {5'b0, mul_b};
  assign f_true_p = {5'b0, f_mul_a} * {5'b0, f_mul_b};
  assign mul_p    = ((chg ? 0 : age) >= LAT - 1) ? true_p : ~true_p;
  assign f_mul_p  = ((f_chg ? 0 : f_age) >= LAT4 - 1) ? f_true_p : ~f_true_p;
  always @(posedge clk) begin
    prev_ab   <= {mul_a, mul_b};
    f_prev_ab <= {f_mul_a, f_mul_b};
    age       <= chg ? 1 : ((age < 100) ? age + 1 : age);
    f_age     <= f_chg ? 1 : ((f_age < 100) ? f_age + 1 : f_age);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  logic [2*W:0] exp_q[$];   // {id, product}
  logic mptr = 1'b1;        // model's last-served requester
  int   acc_cyc = 0;
  logic rr_force = 1'b1;
  logic rr_val   = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives the requested valids and waits until every one has been accepted.
  task automatic issue(input logic u0, input logic u1, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1);
    logic p0, p1, win;
    logic [2*W-1:0] pr;
    int budget;
    @(posedge clk); #1;
    req0_valid = u0; req0_a = a0; req0_b = b0;
    req1_valid = u1; req1_a = a1; req1_b = b1;
    p0 = u0; p1 = u1; budget = 0;
    while ((p0 || p1) && budget < 200) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        win = (req0_valid && req1_valid) ? ~mptr : req1_valid;
        check("one_ready", {31'd0, req0_ready & req1_ready}, 0);
        check("grant_id", {31'd0, req1_ready}, {31'd0, win});
        pr = win ? ({5'b0, a1} * {5'b0, b1}) : ({5'b0, a0} * {5'b0, b0});
        exp_q.push_back({win, pr});
        mptr    = win;
        acc_cyc = cyc;
        if (req0_ready) p0 = 1'b0;
        if (req1_ready) p1 = 1'b0;
      end
      @(posedge clk); #1;
      if (!p0) req0_valid = 1'b0;
      if (!p1) req1_valid = 1'b0;
      budget++;
    end
    if (p0 || p1) begin
      checks++; errors++;
      $display("FAIL accept_timeout: pending %0d%0d after %0d cycles", p0, p1, budget);
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 300) begin
      @(negedge clk); n++;
    end
    if (exp_q.size() != 0 || rsp_valid) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 0);
    check({tag, "_rsp_id"},    {31'd0, rsp_id}, 0);
    check({tag, "_rsp_p"},     {22'd0, rsp_p}, 0);
    check({tag, "_mul_a"},     {27'd0, mul_a}, 0);
    check({tag, "_mul_b"},     {27'd0, mul_b}, 0);
    check({tag, "_busy"},      {31'd0, busy}, 0);
  endtask

  // Response-side ready: forced by directed tests, otherwise random ~70% high.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = rr_force ? rr_val : ($urandom_range(0, 9) < 7);
    end
  end

  // Monitor: pops the scoreboard on each response handshake and checks channel rules.
  logic           prev_hold = 1'b0, prev_hs = 1'b0, prev_v = 1'b0;
  logic [2*W-1:0] hold_p;
  logic           hold_id;
  initial begin
    logic [2*W:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        mptr = 1'b1;
        prev_hold = 1'b0; prev_hs = 1'b0; prev_v = 1'b0;
      end else begin
        if (prev_hs) check("valid_after_handshake", {31'd0, rsp_valid}, 0);
        if (rsp_valid) begin
          check("ready_while_done", {30'd0, req0_ready, req1_ready}, 0);
          check("busy_while_done", {31'd0, busy}, 1);
          if (!prev_v) check("latency", cyc - acc_cyc, LAT + 1);
          if (prev_hold) begin
            check("hold_p", {22'd0, rsp_p}, {22'd0, hold_p});
            check("hold_id", {31'd0, rsp_id}, {31'd0, hold_id});
          end
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: id %0d p %0d with empty queue", rsp_id, rsp_p);
          end else begin
            e = exp_q.pop_front();
            check("rsp_id", {31'd0, rsp_id}, {31'd0, e[2*W]});
            check("rsp_p", {22'd0, rsp_p}, {22'd0, e[2*W-1:0]});
          end
        end
        prev_hold = rsp_valid && !rsp_ready;
        hold_p    = rsp_p;
        hold_id   = rsp_id;
        prev_hs   = rsp_valid && rsp_ready;
        prev_v    = rsp_valid;
      end
    end
  end

  task automatic settle_op(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b);
    int n, t0;
    logic [2*W-1:0] ep;
    ep = {5'b0, a} * {5'b0, b};
    @(posedge clk); #1;
    f_rsp_ready = 1'b0;
    if (sel) begin f_req1_valid = 1'b1; f_req1_a = a; f_req1_b = b; end
    else     begin f_req0_valid = 1'b1; f_req0_a = a; f_req0_b = b; end
    n = 0;
    @(negedge clk);
    while (!(sel ? f_req1_ready : f_req0_ready) && n < 50) begin
      @(negedge clk); n++;
    end
    check("f_accept", {31'd0, sel ? f_req1_ready : f_req0_ready}, 1);
    t0 = cyc;
    @(posedge clk); #1;
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!f_rsp_valid && n < 50) begin
      @(negedge clk); n++;
    end
    check("f_latency", cyc - t0, LAT4 + 1);
    check("f_rsp_p", {22'd0, f_rsp_p}, {22'd0, ep});
    check("f_rsp_id", {31'd0, f_rsp_id}, {31'd0, sel});
    @(posedge clk); #1 f_rsp_ready = 1'b1;
    @(posedge clk); #1 f_rsp_ready = 1'b0;
    @(negedge clk);
    check("f_valid_cleared", {31'd0, f_rsp_valid}, 0);
    check("f_mul_a_hold", {27'd0, f_mul_a}, {27'd0, a});
    check("f_mul_b_hold", {27'd0, f_mul_b}, {27'd0, b});
  endtask

  initial begin
    logic [W-1:0] ra0, rb0, ra1, rb1;
    logic [1:0]   m;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 5'd3; req0_b = 5'd3; req1_a = '0; req1_b = '0;
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    f_req0_a = '0; f_req0_b = '0; f_req1_a = '0; f_req1_b = '0;
    f_rsp_ready = 1'b0;
    rst = 1'b1;
    #1 req0_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("ready_in_reset", {31'd0, req0_ready}, 0);
    end
    check_reset_values("reset");
    @(posedge clk); #1;
    req0_valid = 1'b0; rst = 1'b0;

    // Single op: 31*31 from requester 0
    issue(1'b1, 1'b0, 5'd31, 5'd31, 5'd0, 5'd0);
    drain();

    // Tie from a fresh pointer, twice
    do_reset(1);
    issue(1'b1, 1'b1, 5'd3, 5'd4, 5'd7, 5'd9);
    drain();
    issue(1'b1, 1'b1, 5'd3, 5'd4, 5'd7, 5'd9);
    drain();

    // Backpressure on a requester-1 result
    rr_val = 1'b0;
    issue(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 5'd6);
    while (!rsp_valid) @(negedge clk);
    repeat (5) @(negedge clk);
    rr_val = 1'b1;
    drain();

    // Reset while the operation is in flight
    issue(1'b1, 1'b0, 5'd10, 5'd10, 5'd0, 5'd0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("mid_exec_rst");
    repeat (6) begin
      @(negedge clk);
      check("no_rsp_after_rst", {31'd0, rsp_valid}, 0);
    end
    issue(1'b1, 1'b1, 5'd2, 5'd11, 5'd13, 5'd5);
    drain();

    // Random masks, operands and response backpressure
    rr_force = 1'b0;
    repeat (60) begin
      m   = 2'($urandom_range(1, 3));
      ra0 = 5'($urandom); rb0 = 5'($urandom);
      ra1 = 5'($urandom); rb1 = 5'($urandom);
      issue(m[0], m[1], ra0, rb0, ra1, rb1);
    end
    drain();

    // Every operand pair, alternating requesters
    for (int i = 0; i < 1024; i++) begin
      if (i % 2 == 0) issue(1'b1, 1'b0, 5'(i >> 5), 5'(i), 5'd0, 5'd0);
      else            issue(1'b0, 1'b1, 5'd0, 5'd0, 5'(i >> 5), 5'(i));
    end
    drain();

    // Longer settle window on the second instance
    settle_op(1'b0, 5'd17, 5'd29);
    settle_op(1'b1, 5'($urandom), 5'($urandom));
    settle_op(1'b0, 5'd0, 5'd31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
